// File: rtl/useful_sweep_ctrl_if.sv
// Table-port and sweep-trigger signals between the useful-bit sweep controller
// and its surrounding predictor logic.
interface useful_sweep_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              br_retire;
  logic              sweep_force;
  logic              lookup_req;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_en;
  logic              cnt_clr;
  logic [1:0]        wr_op;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;

  modport master (
    output br_retire, sweep_force, lookup_req, cnt_addr,
    input  cnt_en, cnt_clr, wr_op, wr_addr, busy, done
  );

  modport slave (
    input  br_retire, sweep_force, lookup_req, cnt_addr,
    output cnt_en, cnt_clr, wr_op, wr_addr, busy, done
  );
endinterface

// File: rtl/useful_sweep_ctrl.sv
// Useful-bit sweep controller: clears the whole table after reset, then
// periodically clears alternate useful-bit halves, yielding to predictor lookups.
module useful_sweep_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int PERIOD_W = 18
) (
  input  logic                clk,
  input  logic                reset,
  useful_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {INIT, IDLE, SWEEP} state_t;

  state_t              state_q;
  logic                phase_q;
  logic [PERIOD_W-1:0] br_cnt_q;
  logic                done_q;

  logic active;
  logic grant;
  logic last_addr;

  assign active    = !reset && (state_q != IDLE);
  assign grant     = active && !bus.lookup_req;
  assign last_addr = (bus.cnt_addr == {ADDR_W{1'b1}});

  assign bus.cnt_en  = grant;
  // Holding the counter clear in IDLE guarantees every pass starts at 0.
  assign bus.cnt_clr = !reset && (state_q == IDLE);
  assign bus.wr_addr = bus.cnt_addr;
  assign bus.busy    = reset || (state_q != IDLE);
  assign bus.done    = done_q && !reset;

  always_comb begin
    bus.wr_op = 2'b00;
    if (grant) begin
      if (state_q == INIT) bus.wr_op = 2'b01;
      else                 bus.wr_op = phase_q ? 2'b11 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INIT;
      phase_q  <= 1'b0;
      br_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (grant && last_addr) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (grant && last_addr) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            phase_q <= ~phase_q;
          end
        end
        IDLE: begin
          // Both triggers together still enter exactly one sweep.
          if (bus.sweep_force || (bus.br_retire && (br_cnt_q == {PERIOD_W{1'b1}}))) begin
            state_q  <= SWEEP;
            br_cnt_q <= '0;
          end else if (bus.br_retire) begin
            br_cnt_q <= br_cnt_q + 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_useful_sweep_ctrl.sv
// Directed bench for useful_sweep_ctrl with ADDR_W=3, PERIOD_W=4 and a model
// of the external address counter.
module tb_useful_sweep_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  useful_sweep_ctrl_if #(.ADDR_W(3)) bus ();

  useful_sweep_ctrl #(.ADDR_W(3), .PERIOD_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset)            bus.cnt_addr <= '0;
    else if (bus.cnt_clr) bus.cnt_addr <= '0;
    else if (bus.cnt_en)  bus.cnt_addr <= bus.cnt_addr + 3'd1;
  end

  task automatic cyc(input logic rst, input logic br, input logic sf, input logic lk);
    @(negedge clk);
    reset = rst;
    bus.br_retire = br;
    bus.sweep_force = sf;
    bus.lookup_req = lk;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.cnt_en !== 1'b0 ||
          bus.cnt_clr !== 1'b0 || bus.wr_op !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold: busy=%b done=%b en=%b clr=%b op=%b, want 1 0 0 0 00",
                 bus.busy, bus.done, bus.cnt_en, bus.cnt_clr, bus.wr_op);
      end
    end
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (bus.wr_op !== 2'b01 || bus.wr_addr !== k[2:0] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL init_write k=%0d: op=%b addr=%0d busy=%b done=%b, want 01 %0d 1 0",
                 k, bus.wr_op, bus.wr_addr, bus.busy, bus.done, k);
      end
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL init_done: done=%b busy=%b, want 1 0", bus.done, bus.busy);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (bus.done !== 1'b0 || bus.cnt_clr !== 1'b1 || bus.wr_op !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_init: done=%b clr=%b op=%b, want 0 1 00", bus.done, bus.cnt_clr, bus.wr_op);
    end
  endtask

  task automatic test_period_sweep;
    logic [1:0] exp_op;
    for (int s = 0; s < 2; s++) begin
      exp_op = (s == 0) ? 2'b10 : 2'b11;
      for (int i = 0; i < 16; i++) begin
        cyc(0, 1, 0, 0);
        checks++;
        if (bus.busy !== 1'b0 || bus.cnt_clr !== 1'b1) begin
          errors++;
          $display("FAIL period_idle s=%0d i=%0d: busy=%b clr=%b, want 0 1", s, i, bus.busy, bus.cnt_clr);
        end
      end
      for (int k = 0; k < 8; k++) begin
        cyc(0, 0, 0, 0);
        checks++;
        if (bus.wr_op !== exp_op || bus.wr_addr !== k[2:0] || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL period_write s=%0d k=%0d: op=%b addr=%0d busy=%b, want %b %0d 1",
                   s, k, bus.wr_op, bus.wr_addr, bus.busy, exp_op, k);
        end
      end
      cyc(0, 0, 0, 0);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL period_done s=%0d: done=%b busy=%b, want 1 0", s, bus.done, bus.busy);
      end
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_lookup_stall;
    int next_addr = 0;
    int writes = 0;
    cyc(0, 0, 1, 0);
    for (int c = 1; c <= 11; c++) begin
      cyc(0, 0, 0, (c >= 3 && c <= 5));
      checks++;
      if (c >= 3 && c <= 5) begin
        if (bus.wr_op !== 2'b00 || bus.cnt_en !== 1'b0 || bus.cnt_addr !== 3'd2) begin
          errors++;
          $display("FAIL stall c=%0d: op=%b en=%b addr=%0d, want 00 0 2", c, bus.wr_op, bus.cnt_en, bus.cnt_addr);
        end
      end else begin
        if (bus.wr_op !== 2'b10 || bus.wr_addr !== next_addr[2:0]) begin
          errors++;
          $display("FAIL stall_write c=%0d: op=%b addr=%0d, want 10 %0d", c, bus.wr_op, bus.wr_addr, next_addr);
        end
        next_addr++;
        writes++;
      end
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (bus.done !== 1'b1 || writes != 8) begin
      errors++;
      $display("FAIL stall_done: done=%b writes=%0d, want 1 8", bus.done, writes);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_dual_trigger;
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, (k == 2), 0);
      checks++;
      if (bus.wr_op !== 2'b11 || bus.wr_addr !== k[2:0] || (k == 0 && dut.br_cnt_q !== 4'd0)) begin
        errors++;
        $display("FAIL dual_write k=%0d: op=%b addr=%0d brcnt=%0d, want 11 %0d 0",
                 k, bus.wr_op, bus.wr_addr, dut.br_cnt_q, k);
      end
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL dual_done: done=%b, want 1", bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || dut.br_cnt_q !== 4'd0) begin
        errors++;
        $display("FAIL dual_no_queue i=%0d: busy=%b done=%b brcnt=%0d, want 0 0 0",
                 i, bus.busy, bus.done, dut.br_cnt_q);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 9; k++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (bus.wr_op !== 2'b11 || bus.wr_addr !== k[2:0]) begin
        errors++;
        $display("FAIL mid_sweep k=%0d: op=%b addr=%0d, want 11 %0d", k, bus.wr_op, bus.wr_addr, k);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (bus.wr_op !== 2'b00 || bus.cnt_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset i=%0d: op=%b en=%b done=%b busy=%b, want 00 0 0 1",
                 i, bus.wr_op, bus.cnt_en, bus.done, bus.busy);
      end
    end
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (bus.wr_op !== 2'b01 || bus.wr_addr !== k[2:0] || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reinit k=%0d: op=%b addr=%0d done=%b, want 01 %0d 0", k, bus.wr_op, bus.wr_addr, bus.done, k);
      end
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (bus.wr_op !== 2'b10 || bus.wr_addr !== k[2:0]) begin
        errors++;
        $display("FAIL post_reset_sweep k=%0d: op=%b addr=%0d, want 10 %0d", k, bus.wr_op, bus.wr_addr, k);
      end
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_stall_last;
    int dones = 0;
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      checks++;
      if (bus.wr_op !== 2'b00 || bus.cnt_addr !== 3'd7 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL last_stall i=%0d: op=%b addr=%0d busy=%b done=%b, want 00 7 1 0",
                 i, bus.wr_op, bus.cnt_addr, bus.busy, bus.done);
      end
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (bus.wr_op !== 2'b11 || bus.wr_addr !== 3'd7) begin
      errors++;
      $display("FAIL last_write: op=%b addr=%0d, want 11 7", bus.wr_op, bus.wr_addr);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL last_done_count: got %0d pulses, want 1", dones);
    end
  endtask

  initial begin
    bus.br_retire   = 1'b0;
    bus.sweep_force = 1'b0;
    bus.lookup_req  = 1'b0;
    test_reset();
    test_period_sweep();
    test_lookup_stall();
    test_dual_trigger();
    test_reset_mid_sweep();
    test_stall_last();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/useful_sweep_ctrl.md
USEFUL_SWEEP_CTRL -- requirements
Module: useful_sweep_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, width of the table address, giving 2^ADDR_W entries.
REQ-002 Parameter PERIOD_W, default 18, width of the retired-branch counter, giving a sweep period of 2^PERIOD_W retired branches.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 br_retire  input  1  one retired branch this cycle.
REQ-006 sweep_force  input  1  request an immediate useful-bit sweep.
REQ-007 lookup_req  input  1  predictor lookup or update needs the table port this cycle; has priority over the sweep.
REQ-008 cnt_addr  input  ADDR_W  current value of the external address counter.
REQ-009 cnt_en  output  1  increment the external address counter.
REQ-010 cnt_clr  output  1  synchronously clear the external address counter to 0.
REQ-011 wr_op  output  2  table write op: 00 none, 01 clear whole entry, 10 clear useful MSB, 11 clear useful LSB.
REQ-012 wr_addr  output  ADDR_W  table write address, equal to cnt_addr combinationally.
REQ-013 busy  output  1  high in the INIT and SWEEP states.
REQ-014 done  output  1  one-cycle pulse after the final write of an INIT or SWEEP pass.

Function
REQ-015 The FSM SHALL have exactly three states: INIT, IDLE and SWEEP.
REQ-016 The external counter SHALL share reset, hold on cnt_en=0, add 1 on cnt_en=1, and cnt_clr SHALL take priority over cnt_en.
REQ-017 The port SHALL be granted when the state is INIT or SWEEP and lookup_req=0; grant is internal and combinational.
REQ-018 In INIT or SWEEP, outputs SHALL be: cnt_en = grant; cnt_clr = 0; wr_op = none when no grant.
REQ-019 On grant, wr_op SHALL be 01 in INIT, and in SWEEP SHALL be 10 when phase=0 or 11 when phase=1.
REQ-020 In IDLE, outputs SHALL be: cnt_clr = 1, cnt_en = 0, wr_op = 00, so that every pass starts at address 0.
REQ-021 INIT->IDLE and SWEEP->IDLE SHALL occur on a granted cycle with cnt_addr = 2^ADDR_W-1.
  - done=1 in the following cycle.
  - The counter wraps to 0 on that same edge.
REQ-022 Each SWEEP->IDLE transition SHALL toggle the 1-bit phase register; INIT SHALL NOT toggle it.
REQ-023 An internal PERIOD_W-bit branch counter SHALL increment on br_retire only in IDLE, and SHALL hold in INIT and SWEEP.
REQ-024 IDLE->SWEEP SHALL occur on either trigger:
  - br_retire=1 with the branch counter at 2^PERIOD_W-1;
  - sweep_force=1.
  On the transition the branch counter SHALL be set to 0.
REQ-025 If both triggers occur in the same cycle, exactly one SWEEP SHALL be entered.
REQ-026 sweep_force and br_retire SHALL be ignored in INIT and SWEEP; no sweep request is queued.
REQ-027 While lookup_req=1 in INIT or SWEEP, the FSM SHALL stall with no write and no address advance.
  - Resumes at the same address.
  - No entry is skipped or written twice.
REQ-028 A pass SHALL write each address exactly once, in ascending order 0..2^ADDR_W-1.
REQ-029 done SHALL be registered; all other outputs MAY be combinational from state, phase, lookup_req and cnt_addr.

Reset
REQ-030 While reset=1, the block SHALL hold:
  - state = INIT, phase = 0, branch counter = 0;
  - done = 0, busy = 1;
  - cnt_en = 0, cnt_clr = 0, wr_op = 00.
REQ-031 When reset deasserts, the block SHALL begin an INIT pass at cnt_addr = 0.
REQ-032 Reset asserted mid-INIT or mid-SWEEP SHALL abandon the pass with no done pulse and restart from INIT, phase 0.

Verification
REQ-033 The bench SHALL cover each of the following directed scenarios, using ADDR_W=3, PERIOD_W=4 and an external counter model:
- Reset, then lookup_req=0 -> wr_op=01 at addresses 0..7 on 8 consecutive cycles; done pulses in cycle 9; busy falls together with done.
- Sixteen br_retire pulses in IDLE -> SWEEP is entered after the 16th; wr_op=10 at addresses 0..7; done pulses; the second 16-pulse sweep uses wr_op=11.
- lookup_req=1 for cycles 3-5 of a sweep -> wr_op=00 and cnt_addr frozen at 2 for three cycles; addresses 2..7 are then each written once; total pass length is 11 cycles.
- sweep_force=1 together with the 16th br_retire -> exactly one sweep; branch counter reads 0 afterward; sweep_force repeated during SWEEP is ignored.
- Reset asserted at address 5 of a SWEEP with phase=1 -> no done pulse; INIT restarts at address 0; the next sweep uses wr_op=10.
- lookup_req held at 1 through the last address -> no transition until the address-7 write is granted; done pulses exactly once.
